// File: rtl/fc_omem_reader.sv
// ---------------------------------------------------------------------------
// fc_omem_reader
//
// Reads back the FC output memory after a batch has been inferred. The image
// sequencer leaves the CLS_NUM signed scores of image i at addresses
// i*CLS_NUM .. i*CLS_NUM+CLS_NUM-1. On a start pulse this block walks every
// image, computes the argmax of its scores and hands out one predicted class
// per image over a valid/ready interface. It pulses done after the last one.
//
// Optional build macro:
//   FC_OMEM_READER_SCORE_EN  adds output cls_score carrying the winning score
//
// Ports:
//   clk        clock
//   resetn     synchronous active-low reset
//   start      single-cycle pulse, begins batch readback when idle
//   busy       high while reading, draining or offering a result
//   done       one-cycle pulse after the last class was transferred
//   omem_en    read enable to fc_omem port B
//   omem_addr  read address (0 whenever omem_en is low)
//   omem_dout  read data, valid RD_LAT cycles after an enabled address
//   cls_valid  class result valid
//   cls_ready  downstream accept
//   cls_data   argmax class index
//   cls_img    image index belonging to cls_data
//   cls_score  winning signed score (only with FC_OMEM_READER_SCORE_EN)
// ---------------------------------------------------------------------------
module fc_omem_reader #(
   parameter int IMG_NUM = 250,
   parameter int CLS_NUM = 10,
   parameter int DATA_W  = 16,
   parameter int RD_LAT  = 1,
   parameter int OUT_BW  = $clog2(IMG_NUM*CLS_NUM),
   parameter int IMG_BW  = $clog2(IMG_NUM),
   parameter int CLS_BW  = $clog2(CLS_NUM)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              omem_en,
   output logic [OUT_BW-1:0] omem_addr,
   input  logic [DATA_W-1:0] omem_dout,
   output logic              cls_valid,
   input  logic              cls_ready,
   output logic [CLS_BW-1:0] cls_data,
   output logic [IMG_BW-1:0] cls_img
`ifdef FC_OMEM_READER_SCORE_EN
   ,
   output logic [DATA_W-1:0] cls_score
`endif
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_OUT   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [CLS_BW-1:0] LAST_K   = CLS_BW'(CLS_NUM - 1);
   localparam logic [IMG_BW-1:0] LAST_IMG = IMG_BW'(IMG_NUM - 1);
   localparam logic [OUT_BW-1:0] CLS_STEP = OUT_BW'(CLS_NUM);

   logic [2:0]               state;
   logic [IMG_BW-1:0]        img;
   logic [OUT_BW-1:0]        base;
   logic [CLS_BW-1:0]        k;
   logic [CLS_BW-1:0]        cap_k;
   logic [RD_LAT-1:0]        en_pipe;
   logic signed [DATA_W-1:0] max_q;
   logic [CLS_BW-1:0]        idx_q;

   logic                     cap_valid;
   logic                     better;
   logic signed [DATA_W-1:0] nxt_max;
   logic [CLS_BW-1:0]        nxt_idx;

   // Data returning from the BRAM is marked by the read enable delayed by the
   // read latency; cap_k counts arrivals so each score knows its class index.
   assign cap_valid = en_pipe[RD_LAT-1];

   // Running argmax: the first score of an image loads unconditionally, later
   // ones only win when strictly greater, so ties keep the lower index.
   always_comb begin
      better  = 1'b0;
      nxt_max = max_q;
      nxt_idx = idx_q;
      if (cap_k == '0 || $signed(omem_dout) > max_q) begin
         better = 1'b1;
      end
      if (better) begin
         nxt_max = $signed(omem_dout);
         nxt_idx = cap_k;
      end
   end

   // Outputs are decoded from the state. The result registers stay untouched
   // between the last capture of an image and the first capture of the next
   // one, which starts only after the handshake, so they are stable in OUT.
   assign omem_en   = (state == ST_READ);
   assign omem_addr = omem_en ? (base + OUT_BW'(k)) : '0;
   assign cls_valid = (state == ST_OUT);
   assign cls_data  = cls_valid ? idx_q : '0;
   assign cls_img   = cls_valid ? img : '0;
   assign busy      = (state == ST_READ) || (state == ST_DRAIN) || (state == ST_OUT);
   assign done      = (state == ST_DONE);
`ifdef FC_OMEM_READER_SCORE_EN
   assign cls_score = cls_valid ? max_q : '0;
`endif

   // Sequencer, capture pipeline and argmax registers. The per-image base
   // address is a running sum so no multiplier is needed.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         img     <= '0;
         base    <= '0;
         k       <= '0;
         cap_k   <= '0;
         en_pipe <= '0;
         max_q   <= '0;
         idx_q   <= '0;
      end else begin
         en_pipe[0] <= omem_en;
         for (int i = 1; i < RD_LAT; i++) begin
            en_pipe[i] <= en_pipe[i-1];
         end

         if (cap_valid) begin
            max_q <= nxt_max;
            idx_q <= nxt_idx;
            cap_k <= (cap_k == LAST_K) ? '0 : cap_k + CLS_BW'(1);
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_READ;
                  img   <= '0;
                  base  <= '0;
                  k     <= '0;
               end
            end
            ST_READ: begin
               if (k == LAST_K) begin
                  state <= ST_DRAIN;
                  k     <= '0;
               end else begin
                  k <= k + CLS_BW'(1);
               end
            end
            ST_DRAIN: begin
               if (cap_valid && cap_k == LAST_K) begin
                  state <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (cls_ready) begin
                  if (img == LAST_IMG) begin
                     state <= ST_DONE;
                  end else begin
                     state <= ST_READ;
                     img   <= img + IMG_BW'(1);
                     base  <= base + CLS_STEP;
                     k     <= '0;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               img   <= '0;
               base  <= '0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fc_omem_reader.md
Name: fc_omem_reader

Overview:
- Consumer side of the FC output memory that the image sequencer fills at address img*10 + class during batch inference.
- After a batch completes, a start pulse makes this block walk all IMG_NUM images. For each image it reads the CLS_NUM signed scores and computes the argmax.
- It streams one predicted class per image over a valid/ready interface, then pulses done.
- Sits between fc_omem port B and the result/UART logic.

Parameters:
- IMG_NUM, 250, images per batch.
- CLS_NUM, 10, scores per image.
- DATA_W, 16, signed score width.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2).
- OUT_BW, $clog2(IMG_NUM*CLS_NUM), omem address width.
- IMG_BW, $clog2(IMG_NUM), image index width.
- CLS_BW, $clog2(CLS_NUM), class index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; begins batch readback.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last class is transferred.
- omem_en  out  1  read enable to fc_omem port B.
- omem_addr  out  OUT_BW  read address.
- omem_dout  in  DATA_W  read data, valid RD_LAT cycles after an enabled address.
- cls_valid  out  1  class result valid.
- cls_ready  in  1  downstream accept.
- cls_data  out  CLS_BW  argmax class index.
- cls_img  out  IMG_BW  image index of cls_data.

Behaviour:
- Reset (sampled at clk edge while resetn=0): state IDLE; all outputs 0; internal counters/base 0. A reset mid-operation aborts immediately: no done pulse, and no pending result is kept.
- States:
  - IDLE: start=1 -> READ, with img=0, base=0, k=0.
  - READ: omem_en=1 and omem_addr=base+k, for CLS_NUM consecutive cycles (k=0..CLS_NUM-1); then -> DRAIN.
  - DRAIN: wait until the last score is captured (RD_LAT cycles) -> OUT.
  - OUT: cls_valid=1, with cls_data and cls_img held stable until cls_valid&&cls_ready.
    - On handshake, if img==IMG_NUM-1 -> DONE.
    - Otherwise img+=1, base+=CLS_NUM, k=0 -> READ.
  - DONE: done=1 for one cycle, img/base cleared -> IDLE.
- Capture: a shift register of omem_en delayed RD_LAT marks valid returning data. Score k is compared in its arrival cycle.
- Argmax:
  - The first score (k=0) loads max and idx=0 unconditionally.
  - Later scores replace max only if strictly greater (signed compare).
  - On ties the lower index is kept.
- Address arithmetic: base is a running register (add CLS_NUM per image); no multiplier. The maximum address, IMG_NUM*CLS_NUM-1, must fit in OUT_BW.
- Latency: start sampled at edge 0 -> omem_en high in cycles 1..CLS_NUM. The first cls_valid is high in cycle CLS_NUM+1+RD_LAT (cycle 12 for defaults). Each following image starts READ in the cycle after its handshake.
- Backpressure: while cls_valid=1 and cls_ready=0, there are no reads and all outputs are stable. cls_ready asserted while cls_valid=0 is ignored.
- busy=1 in READ/DRAIN/OUT and 0 in IDLE/DONE. start while busy or in DONE is ignored.
- omem_addr is 0 whenever omem_en=0.

Optional Feature:
- FC_OMEM_READER_SCORE_EN
  - Defined: adds output cls_score [DATA_W-1:0], carrying the winning signed score. It has the same valid/hold rules as cls_data and resets to 0.
  - Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- IMG_NUM=2, RD_LAT=1:
  - Image 0 scores 5,3,...,40 at k=7, others <40 -> cls_data=7, cls_img=0.
  - Image 1 reads addresses 10..19.
  - done pulses once, one cycle after the second handshake.
- Tie: image scores 100 at k=2 and k=5, others 0 -> cls_data=2.
- All negative: scores -50..-4, with -3 at k=9 -> cls_data=9. Also a signed check: 0x8000 never wins over 0x0001.
- Backpressure: cls_ready held low 5 cycles after cls_valid -> cls_valid/cls_data/cls_img stable, omem_en=0 throughout. Handshake -> omem_en rises the next cycle with addr=10.
- RD_LAT=2 and the default IMG_NUM=250:
  - First cls_valid arrives at cycle 13.
  - The last image reads addresses 2490..2499.
  - 250 classes are emitted, then done.
  - A start pulse mid-batch is ignored (no restart; busy stays 1).
- Reset: resetn=0 for 1 cycle during READ of image 3 -> next cycle all outputs 0 and IDLE, with no done pulse. A new start then reads from address 0.
